// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Holds the FSM encoding, lane-select width and the alignment helper.
package data_mem_responder_pkg;

    localparam int          DMEM_SEL_W = 4;
    localparam int          CNT_W      = 4;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        DMEM_STATE_IDLE = 2'd0,
        DMEM_STATE_WAIT = 2'd1,
        DMEM_STATE_RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic                  write;
        logic [DMEM_SEL_W-1:0] sel;
        logic [31:0]           wdata;
        logic                  err;
    } dmem_req_t;

    // Legal shapes are single bytes, aligned halfwords and aligned full words.
    function automatic logic sel_misaligned(input logic [DMEM_SEL_W-1:0] sel,
                                            input logic [1:0]            addr_lo);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b0;
            4'b0011, 4'b1100:                   return addr_lo[0];
            4'b1111:                            return (addr_lo != 2'b00);
            default:                            return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_ram_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered read.
// Contents are never reset.
module data_ram_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
            if (byte_en[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: one request at a time, fixed access latency.
// Optional alignment checking with misalign_err is enabled by DMEM_ALIGN_CHECK_EN.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DMEM_SEL_W-1:0] req_sel,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  stall_req
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic                  misalign_err
`endif
);

    localparam logic [CNT_W-1:0] WAIT_INIT =
        (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    dmem_state_t           state, next_state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] cap_addr;
    dmem_req_t             cap_req;
    logic                  req_err;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DMEM_SEL_W-1:0] ram_byte_en;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = sel_misaligned(req_sel, req_addr[1:0]);
`else
    assign req_err = 1'b0;
`endif

    assign accept = req_ready & req_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= DMEM_STATE_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request fields are frozen at acceptance so later bus changes are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            cap_addr <= '0;
            cap_req  <= '0;
        end else if (accept) begin
            cnt      <= WAIT_INIT;
            cap_addr <= req_addr[ADDR_WIDTH+1:2];
            cap_req  <= '{write: req_write, sel: req_sel, wdata: req_wdata, err: req_err};
        end else if (state == DMEM_STATE_WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DMEM_STATE_IDLE: begin
                if (req_valid) begin
                    next_state = (WAIT_CYCLES == 0) ? DMEM_STATE_RESP : DMEM_STATE_WAIT;
                end
            end
            DMEM_STATE_WAIT: begin
                if (cnt == '0) begin
                    next_state = DMEM_STATE_RESP;
                end
            end
            DMEM_STATE_RESP: next_state = DMEM_STATE_IDLE;
            default:         next_state = DMEM_STATE_IDLE;
        endcase
    end

    // The RAM reads the live address in IDLE so data is ready even with no wait cycles.
    always_comb begin
        req_ready   = (state == DMEM_STATE_IDLE) & ~reset;
        resp_valid  = (state == DMEM_STATE_RESP) & ~reset;
        stall_req   = req_valid & ~resp_valid & ~reset;
        ram_addr    = (state == DMEM_STATE_IDLE) ? req_addr[ADDR_WIDTH+1:2] : cap_addr;
        ram_byte_en = '0;
        resp_rdata  = ZERO_WORD;
        if (resp_valid && cap_req.write && !cap_req.err) begin
            ram_byte_en = cap_req.sel;
        end
        if (resp_valid && !cap_req.write && !cap_req.err) begin
            resp_rdata = ram_rdata;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_err = resp_valid & cap_req.err;
`endif

    data_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock   (clock),
        .addr    (ram_addr),
        .byte_en (ram_byte_en),
        .wdata   (cap_req.wdata),
        .rdata   (ram_rdata)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table plus handshake, reset and latency sequences.
// Exercises a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;

    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        req_ready, resp_valid, stall_req;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_sel;
    logic        z_req_ready, z_resp_valid, z_stall_req;
    logic [31:0] z_resp_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign_err, z_misalign_err;
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_sel      (req_sel),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .stall_req    (stall_req)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    data_mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (z_req_valid),
        .req_write    (z_req_write),
        .req_addr     (z_req_addr),
        .req_sel      (z_req_sel),
        .req_wdata    (z_req_wdata),
        .req_ready    (z_req_ready),
        .resp_valid   (z_resp_valid),
        .resp_rdata   (z_resp_rdata),
        .stall_req    (z_stall_req)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .misalign_err (z_misalign_err)
`endif
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[17];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One full transaction on either instance; returns latency (0 = timed out).
    task automatic applyStimulus(input bit use_zero, input logic write,
                                 input logic [31:0] addr, input logic [3:0] sel,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output int lat, output logic err);
        @(negedge clock);
        if (use_zero) begin
            checkOutput("z_req_ready idle", 32'(z_req_ready), 32'd1);
            z_req_write = write; z_req_addr = addr; z_req_sel = sel;
            z_req_wdata = wdata; z_req_valid = 1'b1;
        end else begin
            checkOutput("req_ready idle", 32'(req_ready), 32'd1);
            checkOutput("resp_valid idle", 32'(resp_valid), 32'd0);
            req_write = write; req_addr = addr; req_sel = sel;
            req_wdata = wdata; req_valid = 1'b1;
        end
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) begin
                if (use_zero) begin
                    z_req_valid = 1'b0; z_req_wdata = ~wdata; z_req_addr = addr ^ 32'h4;
                end else begin
                    req_valid = 1'b0; req_wdata = ~wdata; req_addr = addr ^ 32'h4;
                    req_write = ~write;
                end
            end
            if (use_zero ? z_resp_valid : resp_valid) begin
                lat   = k;
                rdata = use_zero ? z_resp_rdata : resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
                err   = use_zero ? z_misalign_err : misalign_err;
`endif
                break;
            end
        end
    endtask

    logic [31:0] rd;
    int          lat;
    logic        err;
    logic [31:0] word10;
    int          acc[$];
    int          nresp;
    logic [31:0] exp3[3];
    logic        saw_resp;
    bit          exp_resp;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        word10 = ALIGN_CHECK ? 32'hDEADBEAA : 32'h0BADF00D;
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'b0001, 32'h0000_00AA, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'b0001, 32'h0,        32'hDEADBEAA, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0014, 4'b1111, 32'h11223344, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0014, 4'b0011, 32'h55667788, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0014, 4'b1111, 32'h0,        32'h11227788, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0018, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0018, 4'b0000, 32'hFFFFFFFF, 32'h0, ALIGN_CHECK};
        vecs[9]  = '{1'b0, 32'h0000_0018, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_1004, 4'b1111, 32'hA5A55A5A, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0004, 4'b1111, 32'h0,        32'hA5A55A5A, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0012, 4'b1111, 32'h0BADF00D, 32'h0, ALIGN_CHECK};
        vecs[13] = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0,        word10, 1'b0};
        vecs[14] = '{1'b1, 32'h0000_0020, 4'b1111, 32'h00C0FFEE, 32'h0, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_0FFC, 4'b1111, 32'h12345678, 32'h0, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0FFC, 4'b0100, 32'h0,        32'h12345678, 1'b0};

        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_sel = 4'b1111; req_wdata = 32'h0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'h0; z_req_sel = 4'b1111;
        z_req_wdata = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset stall_req", 32'(stall_req), 32'd0);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post-reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("post-reset resp_rdata", resp_rdata, 32'h0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, vecs[i].write, vecs[i].addr, vecs[i].sel, vecs[i].wdata,
                          rd, lat, err);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'd3);
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
            if (ALIGN_CHECK) begin
                checkOutput($sformatf("vec%0d misalign_err", i), 32'(err), 32'(vecs[i].exp_err));
            end
        end

        // Held req_valid: three loads back to back, accepted every 4 cycles.
        exp3[0] = word10; exp3[1] = 32'h11227788; exp3[2] = 32'hCAFEF00D;
        @(negedge clock);
        req_write = 1'b0; req_sel = 4'b1111; req_addr = 32'h10; req_valid = 1'b1;
        nresp = 0;
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            #1;
            if (req_ready && req_valid) acc.push_back(c);
            exp_resp = (acc.size() > 0) && (c == acc[acc.size()-1] + 3);
            checkOutput($sformatf("b2b resp_valid c%0d", c), 32'(resp_valid), 32'(exp_resp));
            checkOutput($sformatf("b2b stall_req c%0d", c), 32'(stall_req), 32'(!exp_resp));
            if (resp_valid) begin
                checkOutput($sformatf("b2b rdata %0d", nresp), resp_rdata, exp3[nresp]);
                nresp++;
                req_addr = 32'h10 + 32'(nresp * 4);
                if (nresp == 3) req_valid = 1'b0;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        checkOutput("b2b accept count", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            checkOutput("b2b first accept", 32'(acc[0]), 32'd0);
            checkOutput("b2b gap 1", 32'(acc[1] - acc[0]), 32'd4);
            checkOutput("b2b gap 2", 32'(acc[2] - acc[1]), 32'd4);
        end

        // Reset during WAIT drops the store to 0x20.
        @(negedge clock);
        req_write = 1'b1; req_addr = 32'h20; req_sel = 4'b1111; req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        reset = 1'b1;
        saw_resp = resp_valid;
        @(negedge clock);
        checkOutput("reset-in-wait req_ready", 32'(req_ready), 32'd0);
        saw_resp = saw_resp | resp_valid;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            saw_resp = saw_resp | resp_valid;
        end
        checkOutput("dropped store resp_valid", 32'(saw_resp), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h20, 4'b1111, 32'h0, rd, lat, err);
        checkOutput("dropped store latency", 32'(lat), 32'd3);
        checkOutput("dropped store old value", rd, 32'h00C0FFEE);

        // Zero-wait instance: response on the cycle after accept.
        applyStimulus(1'b1, 1'b1, 32'h8, 4'b1111, 32'h13579BDF, rd, lat, err);
        checkOutput("wait0 store latency", 32'(lat), 32'd1);
        checkOutput("wait0 store rdata", rd, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h8, 4'b1111, 32'h0, rd, lat, err);
        checkOutput("wait0 load latency", 32'(lat), 32'd1);
        checkOutput("wait0 load rdata", rd, 32'h13579BDF);
        applyStimulus(1'b1, 1'b1, 32'h8, 4'b1000, 32'h7700_0000, rd, lat, err);
        applyStimulus(1'b1, 1'b0, 32'h8, 4'b1111, 32'h0, rd, lat, err);
        checkOutput("wait0 merge rdata", rd, 32'h77579BDF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
